// File: rtl/act_feed_ctrl.sv
// Activation skew-buffer feed sequencer: streams a block of SRAM vectors into the
// skew buffer, drains the skew pipeline, and flags which output rows carry live data.
//
// state | meaning
// IDLE  | waiting for an accepted start
// FETCH | issuing one SRAM read per cycle, num_vectors reads in total
// DRAIN | reads finished, waiting for the last row_valid to retire
// DONE  | one-cycle done pulse
module act_feed_ctrl #(
   parameter int SYSTOLIC_SIZE    = 8,
   parameter int ACTIVATION_WIDTH = 8,
   parameter int ADDR_WIDTH       = 8,
   parameter int LEN_WIDTH        = 8
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       start,
   input  logic                                       abort,
   input  logic                                       test_mode_req,
   input  logic [ADDR_WIDTH-1:0]                      base_addr,
   input  logic [LEN_WIDTH-1:0]                       num_vectors,
   output logic                                       mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                      mem_rd_addr,
   input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  mem_rd_data,
   output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  act_flat_out,
   output logic                                       buf_test_mode,
   output logic [SYSTOLIC_SIZE-1:0]                   row_valid,
   output logic                                       busy,
   output logic                                       done
);

   localparam int S  = SYSTOLIC_SIZE;
   localparam int SW = $clog2(S) + 1;
   // One down-counter serves both the read count and the drain length.
   localparam int CW = (LEN_WIDTH > SW) ? LEN_WIDTH : SW;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  test_mode_q, test_mode_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [S-1:1]          vsr_q, vsr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      test_mode_d = test_mode_q;
      rd_en_d     = rd_en_q;
      rd_addr_d   = rd_addr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rd_vld_d    = rd_en_q;
      vsr_d       = {vsr_q[S-2:1], rd_vld_q};

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               test_mode_d = test_mode_req;
               rd_addr_d   = base_addr;
               if (num_vectors == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = FETCH;
                  busy_d  = 1'b1;
                  rd_en_d = 1'b1;
                  cnt_d   = CW'(num_vectors) - CW'(1);
               end
            end
         end
         FETCH: begin
            if (cnt_q == '0) begin
               state_d = DRAIN;
               rd_en_d = 1'b0;
               // Last row_valid falls S-1 cycles after row 0 in skewed mode.
               cnt_d   = test_mode_q ? '0 : CW'(S - 1);
            end else begin
               cnt_d     = cnt_q - CW'(1);
               rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         state_d  = IDLE;
         rd_en_d  = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         rd_vld_d = 1'b0;
         vsr_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         test_mode_q <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_vld_q    <= 1'b0;
         vsr_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         test_mode_q <= test_mode_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         rd_vld_q    <= rd_vld_d;
         vsr_q       <= vsr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_rd_en     = rd_en_q;
   assign mem_rd_addr   = rd_addr_q;
   assign act_flat_out  = rd_vld_q ? mem_rd_data : '0;
   assign buf_test_mode = test_mode_q;
   assign row_valid     = test_mode_q ? {S{rd_vld_q}} : {vsr_q, rd_vld_q};
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
